// File: rtl/or_vector_sequencer_if.sv
// Handshake/bus bundle between the OR-gate self-test sequencer and its surroundings.
// master: the sequencer; slave: whoever issues start and returns the gate output y.
interface or_vector_sequencer_if #(
   parameter int unsigned ERR_W = 8
);
   logic             start;
   logic             y;
   logic             a;
   logic             b;
   logic [1:0]       vec_idx;
   logic             busy;
   logic             mismatch;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_count;

   modport master (
      input  start, y,
      output a, b, vec_idx, busy, mismatch, done, pass, err_count
   );

   modport slave (
      output start, y,
      input  a, b, vec_idx, busy, mismatch, done, pass, err_count
   );
endinterface

// File: rtl/or_vector_sequencer.sv
// On-chip self-test driver for a 2-input OR gate: sweeps the truth table,
// checks y after a settle time, counts mismatches and reports a verdict.
module or_vector_sequencer #(
   parameter int unsigned HOLD_CYCLES = 10,
   parameter int unsigned NUM_PASSES  = 1,
   parameter int unsigned ERR_W       = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   or_vector_sequencer_if.master   bus
);
   localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int unsigned PASS_W = (NUM_PASSES  > 1) ? $clog2(NUM_PASSES)  : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(NUM_PASSES - 1);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         vec_q, vec_d;
   logic [HOLD_W-1:0]  hold_q, hold_d;
   logic [PASS_W-1:0]  pcnt_q, pcnt_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               a_q, a_d, b_q, b_d;
   logic               busy_q, busy_d;
   logic               pass_q, pass_d;
   logic               mismatch_q, mismatch_d;
   logic               done_q, done_d;
   logic               miss_c;

   // Next-state and next-output computation
   always_comb begin
      state_d    = state_q;
      vec_d      = vec_q;
      hold_d     = hold_q;
      pcnt_d     = pcnt_q;
      err_d      = err_q;
      a_d        = a_q;
      b_d        = b_q;
      busy_d     = busy_q;
      pass_d     = pass_q;
      mismatch_d = 1'b0;
      done_d     = 1'b0;
      miss_c     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = DRIVE;
               vec_d   = 2'd0;
               hold_d  = '0;
               pcnt_d  = '0;
               err_d   = '0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               a_d     = 1'b0;
               b_d     = 1'b0;
            end
         end
         DRIVE: begin
            if (hold_q == HOLD_LAST) begin
               state_d = CHECK;
               hold_d  = '0;
            end else begin
               hold_d  = hold_q + HOLD_W'(1);
            end
         end
         CHECK: begin
            // y is only trusted here, after the settle window
            miss_c     = (bus.y != (a_q | b_q));
            mismatch_d = miss_c;
            if (miss_c && (err_q != '1)) begin
               err_d = err_q + ERR_W'(1);
            end
            hold_d = '0;
            if (vec_q != 2'd3) begin
               state_d    = DRIVE;
               vec_d      = vec_q + 2'd1;
               {a_d, b_d} = vec_q + 2'd1;
            end else if (pcnt_q != PASS_LAST) begin
               state_d    = DRIVE;
               vec_d      = 2'd0;
               {a_d, b_d} = 2'd0;
               pcnt_d     = pcnt_q + PASS_W'(1);
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
               pass_d  = (err_d == '0);
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         vec_q      <= 2'd0;
         hold_q     <= '0;
         pcnt_q     <= '0;
         err_q      <= '0;
         a_q        <= 1'b0;
         b_q        <= 1'b0;
         busy_q     <= 1'b0;
         pass_q     <= 1'b0;
         mismatch_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         vec_q      <= vec_d;
         hold_q     <= hold_d;
         pcnt_q     <= pcnt_d;
         err_q      <= err_d;
         a_q        <= a_d;
         b_q        <= b_d;
         busy_q     <= busy_d;
         pass_q     <= pass_d;
         mismatch_q <= mismatch_d;
         done_q     <= done_d;
      end
   end

   assign bus.a         = a_q;
   assign bus.b         = b_q;
   assign bus.vec_idx   = vec_q;
   assign bus.busy      = busy_q;
   assign bus.pass      = pass_q;
   assign bus.mismatch  = mismatch_q;
   assign bus.done      = done_q;
   assign bus.err_count = err_q;
endmodule

// File: tb/tb_or_vector_sequencer.sv
// Randomized self-checking bench for or_vector_sequencer: a timeline model derived
// from the run rules predicts every output on every cycle of each run.
module tb_or_vector_sequencer;
   localparam int unsigned H0 = 10;
   localparam int unsigned N0 = 1;
   localparam int unsigned E0 = 8;
   localparam int unsigned T0 = H0 + 1;
   localparam int unsigned H1 = 2;
   localparam int unsigned N1 = 2;
   localparam int unsigned E1 = 2;
   localparam int unsigned T1 = H1 + 1;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   or_vector_sequencer_if #(.ERR_W(E0)) bus0 ();
   or_vector_sequencer_if #(.ERR_W(E1)) bus1 ();

   or_vector_sequencer #(.HOLD_CYCLES(H0), .NUM_PASSES(N0), .ERR_W(E0)) dut0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0));
   or_vector_sequencer #(.HOLD_CYCLES(H1), .NUM_PASSES(N1), .ERR_W(E1)) dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // A vector fails when the gate's answer (ytab[v]) differs from the OR of its bits
   function automatic bit vec_fails(input int v, input logic [3:0] ytab);
      return ytab[v] != (v != 0);
   endfunction

   function automatic int fails_in(input int nvec, input logic [3:0] ytab);
      int n = 0;
      for (int j = 0; j < nvec; j++) if (vec_fails(j % 4, ytab)) n++;
      return n;
   endfunction

   function automatic int sat(input int n, input int w);
      int mx = (1 << w) - 1;
      return (n > mx) ? mx : n;
   endfunction

   // Caller is at a negedge with dut0 idle; returns at the negedge of the IDLE cycle after done.
   // Interval k = cycle following the k-th edge after the accepting edge.
   task automatic run0(input logic [3:0] ytab, input int restart_at, input bit hold_start);
      int last = int'(N0) * 4 * int'(T0);
      int v, nf;
      bit mexp;
      bus0.start = 1'b1;
      bus0.y     = 1'($urandom);
      @(negedge clk);
      for (int k = 0; k <= last; k++) begin
         v    = (k / int'(T0)) % 4;
         nf   = fails_in(k / int'(T0), ytab);
         mexp = (k > 0 && k % int'(T0) == 0) ? vec_fails((k / int'(T0) - 1) % 4, ytab) : 1'b0;
         if (k == last) v = 3;
         check("vec_idx",  32'(bus0.vec_idx),   32'(v));
         check("a",        32'(bus0.a),         32'((v >> 1) & 1));
         check("b",        32'(bus0.b),         32'(v & 1));
         check("busy",     32'(bus0.busy),      32'd1);
         check("done",     32'(bus0.done),      32'(k == last));
         check("mismatch", 32'(bus0.mismatch),  32'(mexp));
         check("err",      32'(bus0.err_count), 32'(sat(nf, int'(E0))));
         check("pass",     32'(bus0.pass),      32'((k == last) && (nf == 0)));
         // Gate response only matters at the check edge; elsewhere inject noise
         if (k % int'(T0) == int'(H0)) bus0.y = ytab[{bus0.a, bus0.b}];
         else                          bus0.y = 1'($urandom);
         bus0.start = hold_start || (k == restart_at);
         @(negedge clk);
      end
      nf = fails_in(last / int'(T0), ytab);
      check("idle_busy", 32'(bus0.busy),      32'd0);
      check("idle_done", 32'(bus0.done),      32'd0);
      check("idle_mism", 32'(bus0.mismatch),  32'd0);
      check("idle_err",  32'(bus0.err_count), 32'(sat(nf, int'(E0))));
      check("idle_pass", 32'(bus0.pass),      32'(nf == 0));
      check("idle_ab",   32'({bus0.a, bus0.b}), 32'd3);
      bus0.start = hold_start;
   endtask

   task automatic check_all_zero0(input string tag);
      check({tag, "_ab"},   32'({bus0.a, bus0.b}), 32'd0);
      check({tag, "_vec"},  32'(bus0.vec_idx),   32'd0);
      check({tag, "_busy"}, 32'(bus0.busy),      32'd0);
      check({tag, "_mism"}, 32'(bus0.mismatch),  32'd0);
      check({tag, "_done"}, 32'(bus0.done),      32'd0);
      check({tag, "_pass"}, 32'(bus0.pass),      32'd0);
      check({tag, "_err"},  32'(bus0.err_count), 32'd0);
   endtask

   // Stuck-at-0 gate on the narrow two-pass instance: counter must saturate, not wrap
   task automatic run1_stuck0();
      int last = int'(N1) * 4 * int'(T1);
      int nf, pulses = 0;
      bit mexp;
      bus1.start = 1'b1;
      @(negedge clk);
      for (int k = 0; k <= last; k++) begin
         nf   = fails_in(k / int'(T1), 4'b0000);
         mexp = (k > 0 && k % int'(T1) == 0) ? vec_fails((k / int'(T1) - 1) % 4, 4'b0000) : 1'b0;
         check("s_err",  32'(bus1.err_count), 32'(sat(nf, int'(E1))));
         check("s_mism", 32'(bus1.mismatch),  32'(mexp));
         check("s_done", 32'(bus1.done),      32'(k == last));
         check("s_busy", 32'(bus1.busy),      32'd1);
         if (bus1.mismatch) pulses++;
         bus1.y     = (k % int'(T1) == int'(H1)) ? 1'b0 : 1'($urandom);
         bus1.start = 1'b0;
         @(negedge clk);
      end
      check("s_pulses",  32'(pulses),         32'd6);
      check("s_err_end", 32'(bus1.err_count), 32'd3);
      check("s_pass",    32'(bus1.pass),      32'd0);
      check("s_busy0",   32'(bus1.busy),      32'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      bus0.start = 1'b0;
      bus0.y     = 1'b0;
      bus1.start = 1'b0;
      bus1.y     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_all_zero0("rst");
      check("rst1_err", 32'(bus1.err_count), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run0(4'b1110, -1, 1'b0);   // healthy OR gate
      run0(4'b0000, -1, 1'b0);   // stuck-at-0
      run0(4'b1000, -1, 1'b0);   // AND instead of OR
      run0(4'b1110, 20, 1'b0);   // start re-pulsed mid-run is ignored
      run0(4'b1110, -1, 1'b1);   // start held: next run follows after one IDLE cycle
      run0(4'b1110, -1, 1'b0);
      for (int r = 0; r < 4; r++) begin
         run0(4'($urandom), int'($urandom_range(0, 43)), 1'($urandom));
      end
      bus0.start = 1'b0;
      @(negedge clk);

      // Asynchronous reset during vector 10, then a clean sweep
      bus0.start = 1'b1;
      @(negedge clk);
      bus0.start = 1'b0;
      for (int k = 0; k < 2 * int'(T0) + 3; k++) begin
         bus0.y = 1'($urandom);
         @(negedge clk);
      end
      check("pre_rst_vec", 32'(bus0.vec_idx), 32'd2);
      #2 rst_n = 1'b0;
      #1 check_all_zero0("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("post_rst_done", 32'(bus0.done), 32'd0);
         check("post_rst_busy", 32'(bus0.busy), 32'd0);
      end
      run0(4'b1110, -1, 1'b0);

      run1_stuck0();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/or_vector_sequencer.md
Name: or_vector_sequencer

Overview:
Upstream stimulus stage for or_gate. On a start pulse it drives the gate's a/b inputs through the full 2-input truth table (00, 01, 10, 11). It holds each vector for a programmable settle time, samples y and compares it against a|b. It counts mismatches and reports a pass/fail verdict, giving on-chip self-test of the OR stage without a simulation-only bench.

Parameters:
HOLD_CYCLES, 10, settle cycles each vector is held before checking; legal range >=1
NUM_PASSES, 1, number of full truth-table sweeps per run; legal range >=1
ERR_W, 8, width of the mismatch counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  run request; sampled only in IDLE
y  input  1  output of or_gate under test
a  output  1  drives or_gate input a
b  output  1  drives or_gate input b
vec_idx  output  2  current vector index, {a,b} == vec_idx
busy  output  1  high from the cycle after start is accepted until DONE is left
mismatch  output  1  one-cycle pulse; the y check just completed failed
done  output  1  one-cycle pulse at end of run
pass  output  1  verdict: err_count==0 at end of run; valid from done, held until next start
err_count  output  ERR_W  mismatches this run; saturates at all-ones

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; a=b=0, vec_idx=0, busy=0, mismatch=0, done=0, pass=0, err_count=0; hold and pass counters cleared. Reset mid-run aborts immediately. No done is produced.
- All outputs are registered. Release of rst_n is synchronous to the next clk edge.
- States: IDLE, DRIVE, CHECK, DONE.
- IDLE: start=1 at an edge -> DRIVE. On that same edge: vec_idx=0, hold counter=0, pass counter=0, err_count=0, pass=0, busy=1. start=0 -> stay. Outputs a/b/pass/err_count from the previous run are retained.
- DRIVE: {a,b}=vec_idx held constant. Hold counter increments each cycle. After exactly HOLD_CYCLES cycles in DRIVE -> CHECK.
- CHECK: lasts exactly 1 cycle. At the edge leaving CHECK, y is sampled and compared with expected = a|b.
  - On mismatch: err_count increments (saturating at 2^ERR_W-1), and mismatch=1 for the following cycle only.
  - If vec_idx<3: vec_idx++ -> DRIVE, hold counter cleared.
  - If vec_idx==3 and passes remain: vec_idx wraps to 0, pass counter++ -> DRIVE.
  - If vec_idx==3 and this is the last pass: -> DONE.
- DONE: lasts 1 cycle. done=1 and busy=1 during this cycle. pass=(err_count==0), computed including the final CHECK result. Then -> IDLE with busy=0 and done=0. a/b hold the last vector (11).
- Cycles per vector: HOLD_CYCLES+1. done is asserted exactly NUM_PASSES*4*(HOLD_CYCLES+1)+1 cycles after the accepting start edge.
- start while busy (DRIVE/CHECK/DONE): ignored, no effect on state or counters.
- start held high continuously: a new run begins on the first IDLE edge after DONE (back-to-back runs, one IDLE cycle between).
- y is only sampled in CHECK. Glitches or X on y during DRIVE have no effect.
- err_count saturation: it never wraps. pass=0 whenever any mismatch occurred.

Test Plan:
- Correct or_gate, HOLD_CYCLES=10, NUM_PASSES=1, start pulse -> {a,b} sequence 00,01,10,11, each held 11 cycles; done pulse 45 cycles after start edge; err_count=0; pass=1; mismatch never asserted.
- y stuck-at-0, defaults -> mismatch pulses after vectors 01, 10, 11 (3 pulses); err_count=3; pass=0; done at cycle 45.
- y driven by a&b instead of a|b -> mismatches on vectors 01 and 10 only; err_count=2; pass=0.
- ERR_W=2, NUM_PASSES=2, y stuck-at-0 -> 6 failing checks; err_count saturates at 3 and stays 3; done at cycle 89; pass=0.
- rst_n low during vector 10 of a run -> all outputs 0 immediately (asynchronous, before next clk edge); no done pulse; a new start after release runs a full clean sweep with err_count reset.
- start re-pulsed at cycle 20 of a run -> ignored: vector timing unchanged, done still at cycle 45, single done pulse; start held high -> second run begins exactly 1 IDLE cycle after done.
